// File: rtl/alt_vipcto131_common_sync_generator.sv
// Video timing master: free-running h/v counters from programmed mode values,
// registered sync/de/marker outputs, per-pixel request and underflow flag.
module alt_vipcto131_common_sync_generator #(
    parameter int WORD_LENGTH       = 12,
    parameter int TICKS_WORD_LENGTH = 1,
    parameter int TICKS_PER_COUNT   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   mode_update,
    input  logic [WORD_LENGTH-1:0] mode_h_total,
    input  logic [WORD_LENGTH-1:0] mode_h_active,
    input  logic [WORD_LENGTH-1:0] mode_h_sync_start,
    input  logic [WORD_LENGTH-1:0] mode_h_sync_end,
    input  logic [WORD_LENGTH-1:0] mode_v_total,
    input  logic [WORD_LENGTH-1:0] mode_v_active,
    input  logic [WORD_LENGTH-1:0] mode_v_sync_start,
    input  logic [WORD_LENGTH-1:0] mode_v_sync_end,
    input  logic                   mode_h_sync_pol,
    input  logic                   mode_v_sync_pol,
    input  logic                   pix_valid,
    input  logic                   underflow_clear,
    output logic [WORD_LENGTH-1:0] h_count,
    output logic [WORD_LENGTH-1:0] v_count,
    output logic                   h_sync,
    output logic                   v_sync,
    output logic                   de,
    output logic                   sof,
    output logic                   eol,
    output logic                   pix_ready,
    output logic                   underflow,
    output logic                   running
);

    typedef struct packed {
        logic [WORD_LENGTH-1:0] h_total;
        logic [WORD_LENGTH-1:0] h_active;
        logic [WORD_LENGTH-1:0] h_sync_start;
        logic [WORD_LENGTH-1:0] h_sync_end;
        logic [WORD_LENGTH-1:0] v_total;
        logic [WORD_LENGTH-1:0] v_active;
        logic [WORD_LENGTH-1:0] v_sync_start;
        logic [WORD_LENGTH-1:0] v_sync_end;
        logic                   h_sync_pol;
        logic                   v_sync_pol;
    } mode_t;

    typedef enum logic {STOPPED, RUNNING} state_t;

    localparam logic [TICKS_WORD_LENGTH-1:0] TICK_LAST = TICKS_WORD_LENGTH'(TICKS_PER_COUNT - 1);
    localparam mode_t MODE_RESET = '{h_sync_pol: 1'b1, v_sync_pol: 1'b1, default: '0};

    state_t                       state;
    mode_t                        pending;
    mode_t                        active;
    mode_t                        mode_in;
    logic [WORD_LENGTH-1:0]       h_cnt;
    logic [WORD_LENGTH-1:0]       v_cnt;
    logic [TICKS_WORD_LENGTH-1:0] tick;
    logic                         first_tick_q;

    logic tick_term, h_wrap, v_wrap, frame_end;
    logic de_c, hs_raw, vs_raw, sof_c, eol_c;

    assign mode_in = '{h_total: mode_h_total, h_active: mode_h_active,
                       h_sync_start: mode_h_sync_start, h_sync_end: mode_h_sync_end,
                       v_total: mode_v_total, v_active: mode_v_active,
                       v_sync_start: mode_v_sync_start, v_sync_end: mode_v_sync_end,
                       h_sync_pol: mode_h_sync_pol, v_sync_pol: mode_v_sync_pol};

    // Counter decode: pixel-advance, wrap and per-pixel flags from the internal counts
    always_comb begin
        tick_term = (TICKS_PER_COUNT <= 1) || (tick == TICK_LAST);
        h_wrap    = h_cnt >= active.h_total;
        v_wrap    = v_cnt >= active.v_total;
        frame_end = (state == RUNNING) && tick_term && h_wrap && v_wrap;
        de_c      = (h_cnt < active.h_active) && (v_cnt < active.v_active);
        hs_raw    = (h_cnt >= active.h_sync_start) && (h_cnt < active.h_sync_end);
        vs_raw    = (v_cnt >= active.v_sync_start) && (v_cnt < active.v_sync_end);
        sof_c     = (tick == '0) && (h_cnt == '0) && (v_cnt == '0);
        eol_c     = tick_term && (active.h_active != '0) &&
                    (h_cnt == active.h_active - 1'b1) && (v_cnt < active.v_active);
    end

    // Pending mode set captures the inputs on every mode_update pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pending <= MODE_RESET;
        else if (mode_update)
            pending <= mode_in;
    end

    // Active mode follows pending only while stopped or at a frame end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            active <= MODE_RESET;
        else if (state == STOPPED || frame_end)
            active <= pending;
    end

    // Run/stop FSM with tick, horizontal and vertical counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= STOPPED;
            h_cnt <= '0;
            v_cnt <= '0;
            tick  <= '0;
        end else begin
            case (state)
                STOPPED: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    tick  <= '0;
                    if (enable)
                        state <= RUNNING;
                end
                default: begin
                    tick <= tick_term ? '0 : tick + 1'b1;
                    if (tick_term) begin
                        if (h_wrap) begin
                            h_cnt <= '0;
                            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
                        end else begin
                            h_cnt <= h_cnt + 1'b1;
                        end
                    end
                    if (frame_end && !enable)
                        state <= STOPPED;
                end
            endcase
        end
    end

    // Registered outputs, one clock behind the internal counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count      <= '0;
            v_count      <= '0;
            h_sync       <= 1'b0;
            v_sync       <= 1'b0;
            de           <= 1'b0;
            sof          <= 1'b0;
            eol          <= 1'b0;
            first_tick_q <= 1'b0;
        end else if (state == RUNNING) begin
            h_count      <= h_cnt;
            v_count      <= v_cnt;
            h_sync       <= active.h_sync_pol ? hs_raw : !hs_raw;
            v_sync       <= active.v_sync_pol ? vs_raw : !vs_raw;
            de           <= de_c;
            sof          <= sof_c;
            eol          <= eol_c;
            first_tick_q <= (tick == '0);
        end else begin
            h_count      <= '0;
            v_count      <= '0;
            h_sync       <= !active.h_sync_pol;
            v_sync       <= !active.v_sync_pol;
            de           <= 1'b0;
            sof          <= 1'b0;
            eol          <= 1'b0;
            first_tick_q <= 1'b0;
        end
    end

    assign pix_ready = de && first_tick_q;
    assign running   = (state == RUNNING);

    // Sticky underflow; a new error takes priority over a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            underflow <= 1'b0;
        else if (pix_ready && !pix_valid)
            underflow <= 1'b1;
        else if (underflow_clear)
            underflow <= 1'b0;
    end

endmodule

// File: tb/tb_alt_vipcto131_common_sync_generator.sv
// Directed bench: two instances (no pixel repeat, and 2 clocks per pixel)
// driven from shared stimulus, checked against hand-derived timing patterns.
module tb_alt_vipcto131_common_sync_generator;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable, mode_update, pix_valid, underflow_clear;
    logic [W-1:0] m_ht, m_ha, m_hss, m_hse, m_vt, m_va, m_vss, m_vse;
    logic         m_hpol, m_vpol;

    logic [W-1:0] hc1, vc1, hc2, vc2;
    logic         hs1, vs1, de1, sof1, eol1, rdy1, uf1, run1;
    logic         hs2, vs2, de2, sof2, eol2, rdy2, uf2, run2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alt_vipcto131_common_sync_generator #(
        .WORD_LENGTH(W), .TICKS_WORD_LENGTH(1), .TICKS_PER_COUNT(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode_update(mode_update),
        .mode_h_total(m_ht), .mode_h_active(m_ha), .mode_h_sync_start(m_hss),
        .mode_h_sync_end(m_hse), .mode_v_total(m_vt), .mode_v_active(m_va),
        .mode_v_sync_start(m_vss), .mode_v_sync_end(m_vse),
        .mode_h_sync_pol(m_hpol), .mode_v_sync_pol(m_vpol),
        .pix_valid(pix_valid), .underflow_clear(underflow_clear),
        .h_count(hc1), .v_count(vc1), .h_sync(hs1), .v_sync(vs1), .de(de1),
        .sof(sof1), .eol(eol1), .pix_ready(rdy1), .underflow(uf1), .running(run1)
    );

    alt_vipcto131_common_sync_generator #(
        .WORD_LENGTH(W), .TICKS_WORD_LENGTH(1), .TICKS_PER_COUNT(2)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode_update(mode_update),
        .mode_h_total(m_ht), .mode_h_active(m_ha), .mode_h_sync_start(m_hss),
        .mode_h_sync_end(m_hse), .mode_v_total(m_vt), .mode_v_active(m_va),
        .mode_v_sync_start(m_vss), .mode_v_sync_end(m_vse),
        .mode_h_sync_pol(m_hpol), .mode_v_sync_pol(m_vpol),
        .pix_valid(pix_valid), .underflow_clear(underflow_clear),
        .h_count(hc2), .v_count(vc2), .h_sync(hs2), .v_sync(vs2), .de(de2),
        .sof(sof2), .eol(eol2), .pix_ready(rdy2), .underflow(uf2), .running(run2)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packed dut1 observation: {h, v, de, hs, vs, sof, eol, rdy, running, underflow}
    function automatic logic [31:0] exp1(input int m);
        int          ht, n;
        logic [W-1:0] h, v;
        logic        d, hs, vs, s, e, run, uf;
        run = !(m >= 329 && m < 337);
        uf  = (m >= 349 && m < 355) || (m >= 357);
        if (m >= 330 && m < 338)
            return {24'h0, 6'b0, run, uf};
        if (m < 250)      begin ht = 10; n = m % 50;          end
        else if (m < 330) begin ht = 8;  n = (m - 250) % 40;  end
        else              begin ht = 8;  n = (m - 338) % 40;  end
        h  = W'(n % ht);
        v  = W'(n / ht);
        d  = (h < 6) && (v < 3);
        hs = (m >= 378) ? 1'b1 : ((h >= 7) && (h < 9));
        vs = (v == 3);
        s  = (n == 0);
        e  = (h == 5) && (v < 3);
        return {h, v, d, hs, vs, s, e, d, run, uf};
    endfunction

    // Packed dut2 observation: {h, v, de, hs, vs, sof, eol, rdy}, each pixel held 2 clocks
    function automatic logic [29:0] exp2(input int m);
        int           n;
        logic         first;
        logic [W-1:0] h, v;
        logic         d;
        n     = (m / 2) % 50;
        first = (m % 2) == 0;
        h     = W'(n % 10);
        v     = W'(n / 10);
        d     = (h < 6) && (v < 3);
        return {h, v, d, (h >= 7) && (h < 9), v == 3, (n == 0) && first,
                (h == 5) && (v < 3) && !first, d && first};
    endfunction

    initial begin
        logic found;
        reset_n = 1'b0; enable = 1'b0; mode_update = 1'b0;
        pix_valid = 1'b1; underflow_clear = 1'b0;
        m_ht = 9; m_ha = 6; m_hss = 7; m_hse = 9;
        m_vt = 4; m_va = 3; m_vss = 3; m_vse = 4;
        m_hpol = 1'b1; m_vpol = 1'b1;

        repeat (2) @(negedge clk);
        check_val("reset dut1", {hc1, vc1, de1, hs1, vs1, sof1, eol1, rdy1, run1, uf1}, 64'h0);
        check_val("reset dut2", {hc2, vc2, de2, hs2, vs2, sof2, eol2, rdy2, run2, uf2}, 64'h0);

        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) mode_update = 1'b1;
        @(negedge clk) mode_update = 1'b0;
        @(negedge clk);
        check_val("stopped idle", {hs1, vs1, de1, run1}, 64'h0);
        enable = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = sof1;
        end
        check_val("first sof seen", {63'h0, found}, 64'h1);

        if (found) begin
            for (int m = 0; m <= 400; m++) begin
                if (m > 0) @(negedge clk);
                check_val($sformatf("dut1 m=%0d", m),
                          {hc1, vc1, de1, hs1, vs1, sof1, eol1, rdy1, run1, uf1}, exp1(m));
                if (m < 200)
                    check_val($sformatf("dut2 m=%0d", m),
                              {hc2, vc2, de2, hs2, vs2, sof2, eol2, rdy2}, exp2(m));
                case (m)
                    210: begin m_ht = 7; mode_update = 1'b1; end
                    211: mode_update = 1'b0;
                    298: enable = 1'b0;
                    336: enable = 1'b1;
                    348: pix_valid = 1'b0;
                    349: pix_valid = 1'b1;
                    354: underflow_clear = 1'b1;
                    355: underflow_clear = 1'b0;
                    356: begin pix_valid = 1'b0; underflow_clear = 1'b1; end
                    357: begin pix_valid = 1'b1; underflow_clear = 1'b0; end
                    360: begin m_hpol = 1'b0; m_hss = 5; m_hse = 5; mode_update = 1'b1; end
                    361: mode_update = 1'b0;
                    default: ;
                endcase
            end

            #2 reset_n = 1'b0;
            #1;
            check_val("async reset dut1", {hc1, vc1, de1, hs1, vs1, sof1, eol1, rdy1, run1, uf1}, 64'h0);
            check_val("async reset dut2", {hc2, vc2, de2, hs2, vs2, sof2, eol2, rdy2, run2, uf2}, 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
